otf_sd_converter: RTL and testbench

Radix-4 on-the-fly converter that turns a most-significant-digit-first stream of signed digits into a conventional radix-4 digit vector, with optional per-digit negation. It feeds the digit-serial online multiplier datapath, which needs the operand prefixes X[j] and Y[j] in non-redundant form every cycle. Q holds the exact prefix value, and QM holds that value minus one unit in the last written position.

---
 rtl/otf_sd_converter.sv | 86 ++++++++
 tb/tb_otf_sd_converter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/otf_sd_converter.sv
// Radix-4 on-the-fly signed-digit to conventional converter.
// Q holds the exact prefix; QM holds the prefix minus one unit in the last written slot.
module otf_sd_converter #(
  parameter int no_of_digits = 4,
  parameter int radix_bits   = 3,
  parameter int radix        = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [radix_bits-1:0]                  q,
  input  logic                                   q_valid,
  input  logic                                   neg,
  output logic [no_of_digits*radix_bits-1:0]     Q,
  output logic [no_of_digits*radix_bits-1:0]     QM,
  output logic [$clog2(no_of_digits+1)-1:0]      count,
  output logic                                   done
);

  localparam int W  = no_of_digits * radix_bits;
  localparam int CW = $clog2(no_of_digits + 1);
  localparam logic [radix_bits-1:0] ONE_V    = radix_bits'(1);
  localparam logic [radix_bits-1:0] RADIX_V  = radix_bits'(radix);
  localparam logic [radix_bits-1:0] RADIXM_V = radix_bits'(radix - 1);

  logic [W-1:0]            qv_q, qv_d, qmv_q, qmv_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic signed [radix_bits-1:0] d_eff;
  logic [radix_bits-1:0]   d_u, q_dig, qm_dig;
  logic                    d_neg, d_pos, accept;
  int                      off;

  always_comb begin
    d_eff  = neg ? -$signed(q) : $signed(q);
    d_u    = $unsigned(d_eff);
    d_neg  = d_eff[radix_bits-1];
    d_pos  = !d_neg && (d_eff != '0);
    accept = q_valid && !done_q;
    qv_d   = qv_q;
    qmv_d  = qmv_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    q_dig  = '0;
    qm_dig = '0;
    off    = 0;
    if (accept) begin
      off = (no_of_digits - 1 - int'(cnt_q)) * radix_bits;
      if (cnt_q == '0) begin
        qv_d   = '0;
        qmv_d  = '0;
        q_dig  = d_u;
        qm_dig = d_u - ONE_V;
      end else begin
        // Choose which register supplies the prefix, then append the corrected digit.
        qv_d   = d_neg ? qmv_q : qv_q;
        q_dig  = d_neg ? d_u + RADIX_V : d_u;
        qmv_d  = d_pos ? qv_q : qmv_q;
        qm_dig = d_pos ? d_u - ONE_V : d_u + RADIXM_V;
      end
      qv_d[off +: radix_bits]  = q_dig;
      qmv_d[off +: radix_bits] = qm_dig;
      cnt_d  = cnt_q + CW'(1);
      done_d = (cnt_d == CW'(no_of_digits));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      qv_q   <= '0;
      qmv_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      qv_q   <= qv_d;
      qmv_q  <= qmv_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign Q     = qv_q;
  assign QM    = qmv_q;
  assign count = cnt_q;
  assign done  = done_q;

endmodule

// File: tb/tb_otf_sd_converter.sv
// Bench for otf_sd_converter: directed digit streams plus random streams against a value model.
module tb_otf_sd_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  q;
  logic        q_valid;
  logic        neg;
  logic [11:0] Q, QM;
  logic [2:0]  count;
  logic        done;

  int errors = 0;
  int checks = 0;

  otf_sd_converter #(.no_of_digits(4), .radix_bits(3), .radix(4)) dut (
    .clk(clk), .reset(reset), .q(q), .q_valid(q_valid), .neg(neg),
    .Q(Q), .QM(QM), .count(count), .done(done)
  );

  always #5 clk = ~clk;

  // Value scaled by 4^4: slot1 signed, other slots unsigned.
  function automatic int val(input logic [11:0] v);
    return int'($signed(v[11:9])) * 64 + int'(v[8:6]) * 16 + int'(v[5:3]) * 4 + int'(v[2:0]);
  endfunction

  function automatic logic [11:0] pack(input int a, input int b, input int c, input int e);
    logic [2:0] s1, s2, s3, s4;
    s1 = 3'(a); s2 = 3'(b); s3 = 3'(c); s4 = 3'(e);
    return {s1, s2, s3, s4};
  endfunction

  task automatic step(input logic v, input int qi, input logic n, input logic rst_n);
    @(negedge clk);
    reset   = rst_n;
    q_valid = v;
    q       = 3'(qi);
    neg     = n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 2, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (Q !== 12'h0 || QM !== 12'h0 || count !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: Q=%h QM=%h count=%0d done=%b, required 0 0 0 0", Q, QM, count, done);
    end
  endtask

  task automatic test_basic_stream();
    int d[4] = '{1, -1, 2, 0};
    logic [11:0] eq[4], eqm[4];
    eq[0] = pack(1,0,0,0); eqm[0] = pack(0,0,0,0);
    eq[1] = pack(0,3,0,0); eqm[1] = pack(0,2,0,0);
    eq[2] = pack(0,3,2,0); eqm[2] = pack(0,3,1,0);
    eq[3] = 12'h0D0;       eqm[3] = pack(0,3,1,3);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, d[i], 1'b0, 1'b1);
      checks++;
      if (Q !== eq[i] || QM !== eqm[i] || count !== 3'(i + 1) || done !== (i == 3)) begin
        errors++;
        $display("FAIL basic digit%0d: Q=%h QM=%h count=%0d done=%b, required Q=%h QM=%h count=%0d done=%b",
                 i + 1, Q, QM, count, done, eq[i], eqm[i], i + 1, (i == 3));
      end
    end
  endtask

  task automatic test_negative_stream();
    do_reset();
    step(1'b1, -2, 1'b0, 1'b1);
    checks++;
    if (Q[11:9] !== 3'b110 || QM[11:9] !== 3'b101) begin
      errors++;
      $display("FAIL neg_first: Qslot1=%b QMslot1=%b, required 110 101", Q[11:9], QM[11:9]);
    end
    step(1'b1, 1, 1'b0, 1'b1);
    checks++;
    if (Q !== pack(-2,1,0,0) || QM !== pack(-2,0,0,0)) begin
      errors++;
      $display("FAIL neg_second: Q=%h QM=%h, required %h %h", Q, QM, pack(-2,1,0,0), pack(-2,0,0,0));
    end
  endtask

  task automatic test_negate();
    do_reset();
    step(1'b1, 3, 1'b1, 1'b1);
    checks++;
    if (Q !== pack(-3,0,0,0) || QM !== pack(-4,0,0,0)) begin
      errors++;
      $display("FAIL negate: Q=%h QM=%h, required %h %h", Q, QM, pack(-3,0,0,0), pack(-4,0,0,0));
    end
  endtask

  task automatic test_overrun_gaps();
    logic [11:0] sq, sqm;
    do_reset();
    step(1'b1, 2, 1'b0, 1'b1);
    sq = Q; sqm = QM;
    step(1'b0, -3, 1'b0, 1'b1);
    step(1'b0, 1, 1'b1, 1'b1);
    checks++;
    if (Q !== sq || QM !== sqm || count !== 3'd1) begin
      errors++;
      $display("FAIL gap_hold: Q=%h QM=%h count=%0d, required %h %h 1", Q, QM, count, sq, sqm);
    end
    step(1'b1, -1, 1'b0, 1'b1);
    step(1'b1, 3, 1'b0, 1'b1);
    step(1'b1, 1, 1'b0, 1'b1);
    sq = Q; sqm = QM;
    step(1'b1, -3, 1'b0, 1'b1);
    checks++;
    if (Q !== sq || QM !== sqm || count !== 3'd4 || done !== 1'b1) begin
      errors++;
      $display("FAIL overrun: Q=%h QM=%h count=%0d done=%b, required %h %h 4 1", Q, QM, count, done, sq, sqm);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(1'b1, 1, 1'b0, 1'b1);
    step(1'b1, 2, 1'b0, 1'b1);
    step(1'b1, 3, 1'b0, 1'b0);
    checks++;
    if (Q !== 12'h0 || QM !== 12'h0 || count !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: Q=%h QM=%h count=%0d done=%b, required 0 0 0 0", Q, QM, count, done);
    end
    step(1'b1, 3, 1'b0, 1'b1);
    checks++;
    if (Q !== pack(3,0,0,0) || count !== 3'd1) begin
      errors++;
      $display("FAIL after_reset: Q=%h count=%0d, required %h 1", Q, count, pack(3,0,0,0));
    end
  endtask

  task automatic test_random();
    int sum, cnt, d, qi, unit;
    logic v, n;
    for (int s = 0; s < 20; s++) begin
      do_reset();
      sum = 0;
      cnt = 0;
      for (int c = 0; c < 9; c++) begin
        v  = ($urandom_range(0, 9) < 7);
        qi = int'($urandom_range(0, 6)) - 3;
        n  = 1'($urandom_range(0, 1));
        d  = n ? -qi : qi;
        if (v && cnt < 4) begin
          sum += d * (4 ** (3 - cnt));
          cnt++;
        end
        step(v, qi, n, 1'b1);
        unit = (cnt == 0) ? 0 : 4 ** (4 - cnt);
        checks++;
        if (val(Q) !== sum || val(QM) !== sum - unit || int'(count) !== cnt || done !== (cnt == 4)) begin
          errors++;
          $display("FAIL random s%0d c%0d: valQ=%0d valQM=%0d count=%0d done=%b, required %0d %0d %0d %b",
                   s, c, val(Q), val(QM), count, done, sum, sum - unit, cnt, (cnt == 4));
        end
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    q_valid = 1'b0;
    q       = '0;
    neg     = 1'b0;
    test_reset();
    test_basic_stream();
    test_negative_stream();
    test_negate();
    test_overrun_gaps();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
